// File: rtl/lsu_pkg.sv
// lsu_pkg: shared opcodes, func3 encodings, FSM states and size decode for the load/store unit.
package lsu_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] SD = 3'b011;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

    // Access size in bytes from the low two func3 bits (1/2/4/8).
    function automatic logic [3:0] size_bytes(input logic [1:0] lg2);
        return 4'd1 << lg2;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store byte-lane shifting/strobes and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_lg2,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_data,
    input  logic [2:0]  ld_func3,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_data,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic [63:0] rdata
);

    logic [63:0] raw;
    logic [7:0]  mask;

    // An 8-byte mask wraps 1<<8 to zero in 8 bits, so the minus one yields 8'hFF.
    always_comb begin
        wdata = st_data << {st_off, 3'b000};
        mask  = (8'h1 << size_bytes(st_lg2)) - 8'h1;
        wstrb = mask << st_off;
        raw   = ld_data >> {ld_off, 3'b000};
        rdata = ld_func3 == LB  ? {{56{raw[7]}}, raw[7:0]} :
                ld_func3 == LH  ? {{48{raw[15]}}, raw[15:0]} :
                ld_func3 == LW  ? {{32{raw[31]}}, raw[31:0]} :
                ld_func3 == LBU ? {56'b0, raw[7:0]} :
                ld_func3 == LHU ? {48'b0, raw[15:0]} :
                ld_func3 == LWU ? {32'b0, raw[31:0]} : raw;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store sequencer between ALU and data memory,
// with writeback alignment and misalign/illegal/timeout exceptions.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int          XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            is_store,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            misalign_exc,
    output logic            illegal_exc,
    output logic            bus_err,
    output logic [XLEN-1:0] exc_addr
);

    state_t          state;
    logic            is_store_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [4:0]      rd_q;
    logic [31:0]     cnt;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic [63:0]     ldata;
    logic [3:0]      sz;
    logic            illegal;
    logic            misalign;

    always_comb begin
        sz       = size_bytes(func3[1:0]);
        illegal  = is_store ? func3[2] : func3 == 3'b111;
        misalign = |(addr[2:0] & (sz[2:0] - 3'd1));
    end

    lsu_align u_align (
        .st_lg2   (func3[1:0]),
        .st_off   (addr[2:0]),
        .st_data  (store_data),
        .ld_func3 (f3_q),
        .ld_off   (addr_q[2:0]),
        .ld_data  (mem_rdata),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rdata    (ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            is_store_q   <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            rd_q         <= '0;
            cnt          <= '0;
            req_ready    <= 1'b1;
            stall        <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_exc <= 1'b0;
            illegal_exc  <= 1'b0;
            bus_err      <= 1'b0;
            exc_addr     <= '0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            illegal_exc  <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    is_store_q <= is_store;
                    f3_q       <= func3;
                    addr_q     <= addr;
                    rd_q       <= rd;
                    cnt        <= '0;
                    req_ready  <= 1'b0;
                    stall      <= 1'b1;
                    if (illegal || misalign) begin
                        state        <= FAULT;
                        illegal_exc  <= illegal;
                        misalign_exc <= !illegal;
                        exc_addr     <= addr;
                    end else begin
                        state     <= ACCESS;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {addr[XLEN-1:3], 3'b000};
                        mem_wdata <= wdata;
                        mem_wstrb <= is_store ? wstrb : 8'h00;
                    end
                end
                ACCESS: if (mem_ack) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 8'h00;
                    if (is_store_q) begin
                        state     <= IDLE;
                        stall     <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        state    <= RESP;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ldata;
                    end
                end else if (TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1)) begin
                    state     <= FAULT;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 8'h00;
                    bus_err   <= 1'b1;
                    exc_addr  <= addr_q;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                RESP, FAULT: begin
                    state     <= IDLE;
                    stall     <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized load/store transactions checked against a spec-level reference model.
module tb_lsu_ctrl;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  func3 = '0;
    logic [63:0] addr = '0;
    logic [63:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        stall, misalign_exc, illegal_exc, bus_err;
    logic [63:0] exc_addr;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] last_wb, last_wdata;
    logic [7:0]  last_strb;

    lsu_ctrl #(.XLEN(64), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .func3(func3), .addr(addr), .store_data(store_data), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .misalign_exc(misalign_exc), .illegal_exc(illegal_exc), .bus_err(bus_err),
        .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] d);
        int sz = 1 << f3[1:0];
        logic [63:0] v = d >> (8 * off);
        logic [63:0] m = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
        v = v & m;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~m;
        return v;
    endfunction

    task automatic run(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd, input logic [4:0] r, input int ack_at,
                       input logic [63:0] rdat);
        int sz, off, nreq, nwb, nmis, nill, nbus, bad, wb_k, idle_k;
        logic ill, mis, tmo;
        logic [63:0] ew, wbd, ea;
        logic [7:0] es;
        logic [4:0] wbr;
        sz = 1 << f3[1:0];
        off = int'(a[2:0]);
        ill = st ? f3[2] : (f3 == 3'b111);
        mis = !ill && (off % sz != 0);
        tmo = !ill && !mis && ack_at > TMO;
        ew = sd << (8 * off);
        es = '0;
        for (int b = 0; b < 8; b++) es[b] = st && b >= off && b < off + sz;
        nreq = 0; nwb = 0; nmis = 0; nill = 0; nbus = 0; bad = 0;
        wb_k = -1; idle_k = -1; wbd = '0; wbr = '0; ea = '0;
        @(negedge clk);
        check("ready_before", req_ready, 1'b1);
        req_valid = 1'b1; is_store = st; func3 = f3; addr = a; store_data = sd; rd = r;
        @(posedge clk); #1;
        req_valid = 1'b0; is_store = $urandom; func3 = 3'($urandom);
        addr = {$urandom, $urandom}; store_data = {$urandom, $urandom}; rd = 5'($urandom);
        for (int k = 1; k <= TMO + 20 && idle_k < 0; k++) begin
            if (mem_req) begin
                nreq++;
                if (nreq == 1) begin last_wdata = mem_wdata; last_strb = mem_wstrb; end
                if (mem_addr !== {a[63:3], 3'b000} || mem_we !== st || mem_wstrb !== es ||
                    (st && mem_wdata !== ew)) bad++;
                if (nreq == ack_at) begin mem_ack = 1'b1; mem_rdata = rdat; end
            end
            if (wb_valid) begin nwb++; wb_k = k - 1; wbd = wb_data; wbr = wb_rd; end
            nmis += int'(misalign_exc);
            nill += int'(illegal_exc);
            nbus += int'(bus_err);
            if (misalign_exc || illegal_exc || bus_err) ea = exc_addr;
            if (req_ready) idle_k = k - 1;
            else if (!stall) bad++;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_rdata = {$urandom, $urandom};
        end
        last_wb = wbd;
        check("mem_stable", 64'(bad), 64'd0);
        check("illegal_cnt", 64'(nill), 64'(ill));
        check("misalign_cnt", 64'(nmis), 64'(mis));
        check("bus_err_cnt", 64'(nbus), 64'(tmo));
        if (ill || mis || tmo) begin
            check("exc_addr", ea, a);
            check("fault_nreq", 64'(nreq), tmo ? 64'(TMO) : 64'd0);
            check("fault_nwb", 64'(nwb), 64'd0);
            check("fault_idle", 64'(idle_k), tmo ? 64'(TMO + 1) : 64'd1);
        end else begin
            check("nreq", 64'(nreq), 64'(ack_at));
            check("nwb", 64'(nwb), st ? 64'd0 : 64'd1);
            check("idle_at", 64'(idle_k), st ? 64'(ack_at) : 64'(ack_at + 1));
            if (!st) begin
                check("wb_at", 64'(wb_k), 64'(ack_at));
                check("wb_data", wbd, model_load(f3, off, rdat));
                check("wb_rd", 64'(wbr), 64'(r));
            end
        end
    endtask

    initial begin
        #12;
        check("rst_ready", req_ready, 1'b1);
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_wb", {wb_valid, misalign_exc, illegal_exc, bus_err}, 4'h0);
        @(negedge clk); rst_n = 1'b1;

        run(1'b0, 3'b010, 64'h1004, 64'h0, 5'd3, 1, 64'h8000_0001_1234_5678);
        check("lw_value", last_wb, 64'hFFFF_FFFF_8000_0001);
        run(1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd0, 1, 64'h0);
        check("sh_strb", 64'(last_strb), 64'hC0);
        check("sh_wdata", last_wdata, 64'hABCD_0000_0000_0000);
        run(1'b0, 3'b011, 64'h3004, 64'h0, 5'd4, 1, 64'h0);
        run(1'b0, 3'b111, 64'h4000, 64'h0, 5'd5, 1, 64'h0);
        run(1'b1, 3'b100, 64'h4008, 64'h0, 5'd5, 1, 64'h0);
        run(1'b0, 3'b100, 64'h0007, 64'h0, 5'd6, 300, 64'h0);
        run(1'b0, 3'b100, 64'h0007, 64'h0, 5'd6, 10, 64'h9C00_0000_0000_0000);
        check("lbu_value", last_wb, 64'h9C);
        run(1'b0, 3'b000, 64'h0010, 64'h0, 5'd0, 2, 64'h80);
        run(1'b1, 3'b011, 64'h0018, 64'h1122_3344_5566_7788, 5'd0, TMO, 64'h0);

        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; func3 = 3'b011; addr = 64'h5000;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_req", mem_req, 1'b1);
        rst_n = 1'b0; #1;
        check("arst_req", mem_req, 1'b0);
        check("arst_ready", req_ready, 1'b1);
        check("arst_stall", stall, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        run(1'b0, 3'b011, 64'h5008, 64'h0, 5'd7, 1, 64'hDEAD_BEEF_0BAD_F00D);

        for (int i = 0; i < 150; i++) begin
            logic [63:0] a;
            int ack;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            ack = (i % 60 == 59) ? 400 : int'($urandom_range(1, 6));
            run(1'($urandom), 3'($urandom), a, {$urandom, $urandom}, 5'($urandom), ack,
                {$urandom, $urandom});
            @(negedge clk); mem_ack = 1'($urandom);
            @(posedge clk); #1; mem_ack = 1'b0;
            check("idle_ack_wb", wb_valid, 1'b0);
            check("idle_ack_stall", stall, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
